// File: rtl/post_uart_bridge.sv
// Host UART <-> POST byte interface bridge: 8N1 receiver feeding a 4-deep FIFO
// toward the target, and an 8N1 transmitter draining target bytes to the host.
module post_uart_bridge #(
  parameter int REFCLK_FREQ = 48000000,
  parameter int BAUD        = 115200
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic [7:0] rxout,
  input  logic       rxfull,
  output logic       rxreset,
  output logic [7:0] txin,
  input  logic       txempty,
  output logic       txstart,
  output logic       overrun
);
  localparam int BIT_TICKS  = (REFCLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CW         = $clog2(BIT_TICKS + 1);
  // Counters load N-1 and act on the cycle they read zero, so a load spans N cycles.
  localparam logic [CW-1:0] BIT_LD  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF_TICKS - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHIGH} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  // ---------------- receiver ----------------
  logic [1:0]    rxd_sync;
  logic          rxd_s;
  rx_state_t     r_state, r_next;
  logic [CW-1:0] r_cnt, r_cnt_n;
  logic [2:0]    r_bit, r_bit_n;
  logic [7:0]    r_shift, r_shift_n;
  logic          rx_push;

  assign rxd_s = rxd_sync[1];

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      rxd_sync <= 2'b11;
      r_state  <= R_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
    end else begin
      rxd_sync <= {rxd_sync[0], uart_rxd};
      r_state  <= r_next;
      r_cnt    <= r_cnt_n;
      r_bit    <= r_bit_n;
      r_shift  <= r_shift_n;
    end
  end

  always_comb begin
    r_next    = r_state;
    r_cnt_n   = (r_cnt != '0) ? r_cnt - CW'(1) : '0;
    r_bit_n   = r_bit;
    r_shift_n = r_shift;
    rx_push   = 1'b0;
    case (r_state)
      R_IDLE: if (!rxd_s) begin
        r_next  = R_START;
        r_cnt_n = HALF_LD;
      end
      R_START: if (r_cnt == '0) begin
        if (!rxd_s) begin
          r_next  = R_DATA;
          r_cnt_n = BIT_LD;
          r_bit_n = '0;
        end else begin
          r_next  = R_IDLE;
        end
      end
      R_DATA: if (r_cnt == '0) begin
        r_shift_n = {rxd_s, r_shift[7:1]};
        r_cnt_n   = BIT_LD;
        if (r_bit == 3'd7) r_next = R_STOP;
        else               r_bit_n = r_bit + 3'd1;
      end
      R_STOP: if (r_cnt == '0) begin
        if (rxd_s) begin
          rx_push = 1'b1;
          r_next  = R_IDLE;
        end else begin
          r_next  = R_WAITHIGH;
        end
      end
      R_WAITHIGH: if (rxd_s) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // ---------------- host-to-target FIFO ----------------
  logic [7:0] fifo [4];
  logic [1:0] wp, rp;
  logic [2:0] count;
  logic       pop, push_ok;

  // Feeding only when txstart was low keeps strobes at least one cycle apart.
  assign pop     = (count != 3'd0) && txempty && !txstart;
  assign push_ok = rx_push && ((count != 3'd4) || pop);

  always_ff @(posedge refclk) begin
    if (push_ok) fifo[wp] <= r_shift;
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      txstart <= 1'b0;
      txin    <= '0;
      overrun <= 1'b0;
    end else begin
      count   <= count + 3'(push_ok) - 3'(pop);
      txstart <= pop;
      if (push_ok) wp <= wp + 2'd1;
      if (pop) begin
        rp   <= rp + 2'd1;
        txin <= fifo[rp];
      end
      if (rx_push && !push_ok) overrun <= 1'b1;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t     t_state, t_next;
  logic [CW-1:0] t_cnt, t_cnt_n;
  logic [2:0]    t_bit, t_bit_n;
  logic [7:0]    t_sh, t_sh_n;
  logic          txd_n, rxreset_n;

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      t_state  <= T_IDLE;
      t_cnt    <= '0;
      t_bit    <= '0;
      t_sh     <= '0;
      uart_txd <= 1'b1;
      rxreset  <= 1'b0;
    end else begin
      t_state  <= t_next;
      t_cnt    <= t_cnt_n;
      t_bit    <= t_bit_n;
      t_sh     <= t_sh_n;
      uart_txd <= txd_n;
      rxreset  <= rxreset_n;
    end
  end

  always_comb begin
    t_next    = t_state;
    t_cnt_n   = (t_cnt != '0) ? t_cnt - CW'(1) : '0;
    t_bit_n   = t_bit;
    t_sh_n    = t_sh;
    rxreset_n = 1'b0;
    case (t_state)
      T_IDLE: if (rxfull && !rxreset) begin
        t_next    = T_START;
        t_cnt_n   = BIT_LD;
        t_sh_n    = rxout;
        rxreset_n = 1'b1;
      end
      T_START: if (t_cnt == '0) begin
        t_next  = T_DATA;
        t_cnt_n = BIT_LD;
        t_bit_n = '0;
      end
      T_DATA: if (t_cnt == '0) begin
        t_cnt_n = BIT_LD;
        if (t_bit == 3'd7) t_next = T_STOP;
        else begin
          t_bit_n = t_bit + 3'd1;
          t_sh_n  = {1'b0, t_sh[7:1]};
        end
      end
      T_STOP: if (t_cnt == '0) t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
    // Line level follows the state being entered, so uart_txd stays registered.
    case (t_next)
      T_START: txd_n = 1'b0;
      T_DATA:  txd_n = t_sh_n[0];
      default: txd_n = 1'b1;
    endcase
  end
endmodule
